router_arbiter: RTL

ROUTER_ARBITER -- requirements
Module: router_arbiter

---
 rtl/router_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/router_arbiter.sv
// Four-requester round-robin arbiter routing words to four registered output ports.
// Grants are combinational; a blocked destination never stalls requests to free ports.
module router_arbiter #(
    parameter int DW   = 16,
    parameter int NSRC = 4,
    parameter int NDST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [3:0]      src_valid,
    input  logic [4*DW-1:0] src_data,
    input  logic [7:0]      src_dest,
    output logic [3:0]      src_ready,
    output logic [3:0]      out_valid,
    output logic [DW-1:0]   out_data_0,
    output logic [DW-1:0]   out_data_1,
    output logic [DW-1:0]   out_data_2,
    output logic [DW-1:0]   out_data_3,
    input  logic [3:0]      out_ready,
    output logic [15:0]     xfer_cnt
);

    logic [1:0]    ptr;
    logic [DW-1:0] word [NSRC];
    logic [1:0]    dest [NSRC];
    logic [DW-1:0] port_data [NDST];
    logic [3:0]    port_free;
    logic [3:0]    eligible;
    logic [3:0]    grant;
    logic [1:0]    gidx;
    logic [1:0]    idx;
    logic          found;
    logic          xfer;
    logic [3:0]    load;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            word[i] = src_data[i*DW +: DW];
            dest[i] = src_dest[2*i +: 2];
        end
    end

    // A port can take a new word if it is empty or is being drained this cycle.
    assign port_free = ~out_valid | out_ready;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            eligible[i] = rst & en & src_valid[i] & port_free[dest[i]];
        end
    end

    // Rotating first-eligible search starting at ptr.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = ptr + 2'(k);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    assign src_ready = grant;
    assign xfer      = found;

    always_comb begin
        load = '0;
        if (xfer) begin
            load[dest[gidx]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            xfer_cnt <= '0;
        end else if (xfer) begin
            ptr      <= gidx + 2'd1;
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    // A load wins over a drain on the same port, so the word is replaced without a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= '0;
            for (int d = 0; d < NDST; d++) begin
                port_data[d] <= '0;
            end
        end else begin
            for (int d = 0; d < NDST; d++) begin
                if (load[d]) begin
                    out_valid[d] <= 1'b1;
                    port_data[d] <= word[gidx];
                end else if (out_ready[d]) begin
                    out_valid[d] <= 1'b0;
                end
            end
        end
    end

    assign out_data_0 = port_data[0];
    assign out_data_1 = port_data[1];
    assign out_data_2 = port_data[2];
    assign out_data_3 = port_data[3];

endmodule
